// File: rtl/window_extractor.sv
// window_extractor: buffers one padded tile, then walks every KERNEL x KERNEL
// window in raster order at a stride latched at capture. One window is
// presented per output handshake, all outputs registered.
module window_extractor #(
  parameter int DATA_WIDTH = 16,
  parameter int TILE_DIM   = 10,
  parameter int KERNEL     = 3
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [TILE_DIM*TILE_DIM*DATA_WIDTH-1:0]  tile_in,
  input  logic                                     valid_in,
  output logic                                     ready_in,
  input  logic [1:0]                               stride,
  output logic [KERNEL*KERNEL*DATA_WIDTH-1:0]      window_out,
  output logic [3:0]                               win_row,
  output logic [3:0]                               win_col,
  output logic                                     win_last,
  output logic                                     valid_out,
  input  logic                                     ready_out
);

  localparam int TW   = TILE_DIM*TILE_DIM*DATA_WIDTH;
  localparam int WW   = KERNEL*KERNEL*DATA_WIDTH;
  localparam int SPAN = TILE_DIM - KERNEL;
  // Largest reachable offset for each stride: ((TILE_DIM-KERNEL)/s)*s
  localparam logic [3:0] LAST_S1 = 4'(SPAN);
  localparam logic [3:0] LAST_S2 = 4'((SPAN/2)*2);
  localparam logic [3:0] LAST_S3 = 4'((SPAN/3)*3);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t         r_state, w_state_nxt;
  logic [TW-1:0]  r_tile;
  logic [1:0]     r_s;
  logic [3:0]     r_last_off;
  logic [3:0]     r_row, r_col;
  logic           r_win_last;
  logic [WW-1:0]  r_win;

  logic           w_accept, w_fire, w_col_wrap;
  logic [1:0]     w_s_eff;
  logic [3:0]     w_last_cap;
  logic [3:0]     w_row_nxt, w_col_nxt;
  logic [3:0]     w_sel_row, w_sel_col;
  logic [TW-1:0]  w_sel_tile;
  logic [WW-1:0]  w_win_nxt;

  // Window mux: selects elements by position only; out-of-range positions
  // (never presented) read as zero rather than indexing past the buffer.
  function automatic logic [WW-1:0] pick(input logic [TW-1:0] t,
                                         input logic [3:0] row,
                                         input logic [3:0] col);
    int idx;
    pick = '0;
    for (int kr = 0; kr < KERNEL; kr++) begin
      for (int kc = 0; kc < KERNEL; kc++) begin
        idx = (int'(row) + kr)*TILE_DIM + int'(col) + kc;
        if (idx < TILE_DIM*TILE_DIM)
          pick[(kr*KERNEL+kc)*DATA_WIDTH +: DATA_WIDTH] = t[idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  endfunction

  assign ready_in   = (r_state == IDLE);
  assign valid_out  = (r_state == SCAN);
  assign window_out = r_win;
  assign win_row    = r_row;
  assign win_col    = r_col;
  assign win_last   = r_win_last;

  assign w_accept   = ready_in && valid_in;
  assign w_fire     = valid_out && ready_out;
  assign w_s_eff    = (stride == 2'd0) ? 2'd1 : stride;
  assign w_col_wrap = (r_col == r_last_off);
  assign w_row_nxt  = w_col_wrap ? r_row + {2'b00, r_s} : r_row;
  assign w_col_nxt  = w_col_wrap ? 4'd0 : r_col + {2'b00, r_s};

  // Capture loads window (0,0) straight from the incoming tile
  assign w_sel_tile = w_accept ? tile_in : r_tile;
  assign w_sel_row  = w_accept ? 4'd0 : w_row_nxt;
  assign w_sel_col  = w_accept ? 4'd0 : w_col_nxt;
  assign w_win_nxt  = pick(w_sel_tile, w_sel_row, w_sel_col);

  // Last offset for the stride being captured
  always_comb begin
    w_last_cap = LAST_S1;
    case (w_s_eff)
      2'd2:    w_last_cap = LAST_S2;
      2'd3:    w_last_cap = LAST_S3;
      default: w_last_cap = LAST_S1;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: capture starts a scan, handshake on the final window ends it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (valid_in) w_state_nxt = SCAN;
      SCAN:    if (w_fire && r_win_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Tile buffer: contents are don't-care until a capture, so no reset
  always_ff @(posedge clk) begin
    if (w_accept) r_tile <= tile_in;
  end

  // Position counters and registered window outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s        <= 2'd1;
      r_last_off <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_win_last <= 1'b0;
      r_win      <= '0;
    end else if (w_accept) begin
      r_s        <= w_s_eff;
      r_last_off <= w_last_cap;
      r_row      <= '0;
      r_col      <= '0;
      r_win      <= w_win_nxt;
      r_win_last <= (w_last_cap == 4'd0);
    end else if (w_fire) begin
      if (r_win_last) begin
        r_row      <= '0;
        r_col      <= '0;
        r_win_last <= 1'b0;
      end else begin
        r_row      <= w_row_nxt;
        r_col      <= w_col_nxt;
        r_win      <= w_win_nxt;
        r_win_last <= (w_row_nxt == r_last_off) && (w_col_nxt == r_last_off);
      end
    end
  end

endmodule

// File: tb/tb_window_extractor.sv
// Bench for window_extractor: random tiles and strides, reference windows
// derived from the position/stride rules, with backpressure and reset cases.
module tb_window_extractor;
  localparam int DW = 16;
  localparam int TD = 10;
  localparam int K  = 3;
  localparam int TW = TD*TD*DW;
  localparam int WW = K*K*DW;

  typedef logic [TW-1:0] tile_t;
  typedef logic [WW-1:0] win_t;

  logic        clk = 0;
  logic        rst_n = 0;
  tile_t       tile_in = '0;
  logic        valid_in = 0;
  logic        ready_in;
  logic [1:0]  stride = 0;
  win_t        window_out;
  logic [3:0]  win_row, win_col;
  logic        win_last, valid_out;
  logic        ready_out = 0;

  int checks = 0;
  int errors = 0;

  int   obs_row[$], obs_col[$];
  bit   obs_last[$];
  win_t obs_win[$];
  int   exp_row[$], exp_col[$];
  bit   exp_last[$];
  win_t exp_win[$];

  window_extractor #(.DATA_WIDTH(DW), .TILE_DIM(TD), .KERNEL(K)) dut (
    .clk(clk), .rst_n(rst_n), .tile_in(tile_in), .valid_in(valid_in),
    .ready_in(ready_in), .stride(stride), .window_out(window_out),
    .win_row(win_row), .win_col(win_col), .win_last(win_last),
    .valid_out(valid_out), .ready_out(ready_out)
  );

  always #5 clk = ~clk;

  // Reference: enumerate every window position the stride reaches
  function automatic void build_exp(input tile_t t, input int s);
    int es, r, c;
    win_t w;
    es = (s == 0) ? 1 : s;
    exp_row.delete(); exp_col.delete(); exp_last.delete(); exp_win.delete();
    for (r = 0; r <= TD-K; r += es)
      for (c = 0; c <= TD-K; c += es) begin
        for (int kr = 0; kr < K; kr++)
          for (int kc = 0; kc < K; kc++)
            w[(kr*K+kc)*DW +: DW] = t[((r+kr)*TD + c+kc)*DW +: DW];
        exp_row.push_back(r);
        exp_col.push_back(c);
        exp_last.push_back((r+es > TD-K) && (c+es > TD-K));
        exp_win.push_back(w);
      end
  endfunction

  function automatic tile_t rand_tile();
    tile_t t;
    for (int i = 0; i < TD*TD; i++) t[i*DW +: DW] = DW'($urandom);
    return t;
  endfunction

  function automatic tile_t ramp_tile();
    tile_t t;
    for (int i = 0; i < TD*TD; i++) t[i*DW +: DW] = DW'(i);
    return t;
  endfunction

  function automatic win_t pack9(input int e0, input int e1, input int e2,
                                 input int e3, input int e4, input int e5,
                                 input int e6, input int e7, input int e8);
    int   v[9];
    win_t w;
    v = '{e0, e1, e2, e3, e4, e5, e6, e7, e8};
    for (int k = 0; k < 9; k++) w[k*DW +: DW] = DW'(v[k]);
    return w;
  endfunction

  // Drive a tile from a negedge until accepted; returns at the negedge after capture
  task automatic send_tile(input tile_t t, input logic [1:0] s, output bit to);
    tile_in = t; stride = s; valid_in = 1; to = 1;
    for (int i = 0; i < 500; i++) begin
      if (ready_in) begin to = 0; break; end
      @(negedge clk);
    end
    @(negedge clk);
    valid_in = 0;
  endtask

  // Record accepted beats until win_last or max_beats; returns one negedge later
  task automatic collect(input int max_beats, input int rdy_pct,
                         output bit to, output int ncyc, output int stab_err);
    bit stalled;
    logic [WW+10-1:0] prev, cur;
    bit done;
    obs_row.delete(); obs_col.delete(); obs_last.delete(); obs_win.delete();
    to = 1; ncyc = 0; stab_err = 0; stalled = 0; prev = '0; done = 0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      ready_out = ($urandom_range(99) < rdy_pct);
      cur = {window_out, win_row, win_col, win_last, valid_out};
      if (stalled && cur !== prev) stab_err++;
      stalled = valid_out && !ready_out;
      prev = cur;
      ncyc++;
      if (valid_out && ready_out) begin
        obs_row.push_back(int'(win_row));
        obs_col.push_back(int'(win_col));
        obs_last.push_back(win_last);
        obs_win.push_back(window_out);
        if (win_last || obs_row.size() == max_beats) begin
          to = 0; done = 1;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (ready_in !== 1 || valid_out !== 0 || win_last !== 0 || window_out !== '0 ||
        win_row !== 0 || win_col !== 0) begin
      errors++;
      $display("FAIL reset_low: rdy_in=%b vld=%b last=%b row=%0d col=%0d win=%h (want 1 0 0 0 0 0)",
               ready_in, valid_out, win_last, win_row, win_col, window_out);
    end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (ready_in !== 1 || valid_out !== 0 || win_last !== 0 || window_out !== '0) begin
      errors++;
      $display("FAIL reset_release: rdy_in=%b vld=%b last=%b win=%h (want 1 0 0 0)",
               ready_in, valid_out, win_last, window_out);
    end
  endtask

  task automatic test_stride1_ramp();
    bit to; int ncyc, se;
    tile_t t;
    t = ramp_tile();
    build_exp(t, 1);
    ready_out = 1;
    send_tile(t, 2'd1, to);
    checks++;
    if (to || valid_out !== 1 || win_row !== 0 || win_col !== 0 ||
        window_out !== pack9(0, 1, 2, 10, 11, 12, 20, 21, 22)) begin
      errors++;
      $display("FAIL ramp_first: to=%b vld=%b row=%0d col=%0d win=%h", to, valid_out, win_row, win_col, window_out);
    end
    collect(0, 100, to, ncyc, se);
    checks++;
    if (to || obs_row.size() != 64 || ncyc != 64) begin
      errors++;
      $display("FAIL ramp_count: to=%b beats=%0d cycles=%0d want 64/64", to, obs_row.size(), ncyc);
    end
    for (int i = 0; i < obs_row.size() && i < exp_row.size(); i++) begin
      checks++;
      if (obs_row[i] != exp_row[i] || obs_col[i] != exp_col[i] ||
          obs_last[i] != exp_last[i] || obs_win[i] !== exp_win[i]) begin
        errors++;
        $display("FAIL ramp_beat%0d: got r%0d c%0d l%0b w=%h want r%0d c%0d l%0b w=%h", i,
                 obs_row[i], obs_col[i], obs_last[i], obs_win[i],
                 exp_row[i], exp_col[i], exp_last[i], exp_win[i]);
      end
    end
    if (obs_row.size() == 64) begin
      checks++;
      if (obs_row[63] != 7 || obs_col[63] != 7 || !obs_last[63] ||
          obs_win[63] !== pack9(77, 78, 79, 87, 88, 89, 97, 98, 99)) begin
        errors++;
        $display("FAIL ramp_last: r%0d c%0d l%0b w=%h", obs_row[63], obs_col[63], obs_last[63], obs_win[63]);
      end
    end
    checks++;
    if (valid_out !== 0 || ready_in !== 1 || win_last !== 0) begin
      errors++;
      $display("FAIL ramp_after: vld=%b rdy_in=%b last=%b want 0 1 0", valid_out, ready_in, win_last);
    end
  endtask

  task automatic test_strides();
    bit to; int ncyc, se;
    tile_t t;
    int svals[3] = '{2, 3, 0};
    int cnts[3]  = '{16, 9, 64};
    for (int j = 0; j < 3; j++) begin
      t = rand_tile();
      build_exp(t, svals[j]);
      ready_out = 1;
      send_tile(t, 2'(svals[j]), to);
      collect(0, 100, to, ncyc, se);
      checks++;
      if (to || obs_row.size() != cnts[j] || ncyc != cnts[j]) begin
        errors++;
        $display("FAIL stride%0d_count: to=%b beats=%0d cycles=%0d want %0d", svals[j], to, obs_row.size(), ncyc, cnts[j]);
      end
      for (int i = 0; i < obs_row.size() && i < exp_row.size(); i++) begin
        checks++;
        if (obs_row[i] != exp_row[i] || obs_col[i] != exp_col[i] ||
            obs_last[i] != exp_last[i] || obs_win[i] !== exp_win[i]) begin
          errors++;
          $display("FAIL stride%0d_beat%0d: got r%0d c%0d l%0b w=%h want r%0d c%0d l%0b w=%h", svals[j], i,
                   obs_row[i], obs_col[i], obs_last[i], obs_win[i],
                   exp_row[i], exp_col[i], exp_last[i], exp_win[i]);
        end
      end
      checks++;
      if (valid_out !== 0 || ready_in !== 1) begin
        errors++;
        $display("FAIL stride%0d_after: vld=%b rdy_in=%b want 0 1", svals[j], valid_out, ready_in);
      end
    end
  endtask

  task automatic test_backpressure();
    bit to; int ncyc, se;
    tile_t t;
    t = rand_tile();
    build_exp(t, 1);
    ready_out = 0;
    send_tile(t, 2'd1, to);
    collect(0, 45, to, ncyc, se);
    checks++;
    if (to || obs_row.size() != 64) begin
      errors++;
      $display("FAIL bp_count: to=%b beats=%0d want 64", to, obs_row.size());
    end
    checks++;
    if (se != 0) begin
      errors++;
      $display("FAIL bp_stable: %0d stalled cycles changed outputs, want 0", se);
    end
    for (int i = 0; i < obs_row.size() && i < exp_row.size(); i++) begin
      checks++;
      if (obs_row[i] != exp_row[i] || obs_col[i] != exp_col[i] ||
          obs_last[i] != exp_last[i] || obs_win[i] !== exp_win[i]) begin
        errors++;
        $display("FAIL bp_beat%0d: got r%0d c%0d l%0b w=%h want r%0d c%0d l%0b w=%h", i,
                 obs_row[i], obs_col[i], obs_last[i], obs_win[i],
                 exp_row[i], exp_col[i], exp_last[i], exp_win[i]);
      end
    end
  endtask

  task automatic test_valid_in_during_scan();
    bit to; int ncyc, se;
    tile_t ta, tb;
    ta = rand_tile();
    tb = rand_tile();
    build_exp(ta, 2);
    ready_out = 1;
    send_tile(ta, 2'd2, to);
    tile_in = tb; stride = 2'd3; valid_in = 1;
    collect(0, 70, to, ncyc, se);
    for (int i = 0; i < obs_row.size() && i < exp_row.size(); i++) begin
      checks++;
      if (obs_row[i] != exp_row[i] || obs_col[i] != exp_col[i] ||
          obs_last[i] != exp_last[i] || obs_win[i] !== exp_win[i]) begin
        errors++;
        $display("FAIL hold_a_beat%0d: got r%0d c%0d l%0b w=%h want r%0d c%0d l%0b w=%h", i,
                 obs_row[i], obs_col[i], obs_last[i], obs_win[i],
                 exp_row[i], exp_col[i], exp_last[i], exp_win[i]);
      end
    end
    checks++;
    if (to || obs_row.size() != 16 || ready_in !== 1) begin
      errors++;
      $display("FAIL hold_a_end: to=%b beats=%0d rdy_in=%b want 16 beats rdy_in 1", to, obs_row.size(), ready_in);
    end
    build_exp(tb, 3);
    @(negedge clk);
    valid_in = 0;
    checks++;
    if (valid_out !== 1 || win_row !== 0 || win_col !== 0 || window_out !== exp_win[0]) begin
      errors++;
      $display("FAIL hold_b_accept: vld=%b r%0d c%0d w=%h want 1 r0 c0 w=%h", valid_out, win_row, win_col, window_out, exp_win[0]);
    end
    collect(0, 100, to, ncyc, se);
    checks++;
    if (to || obs_row.size() != 9) begin
      errors++;
      $display("FAIL hold_b_count: to=%b beats=%0d want 9", to, obs_row.size());
    end
    for (int i = 0; i < obs_row.size() && i < exp_row.size(); i++) begin
      checks++;
      if (obs_row[i] != exp_row[i] || obs_col[i] != exp_col[i] ||
          obs_last[i] != exp_last[i] || obs_win[i] !== exp_win[i]) begin
        errors++;
        $display("FAIL hold_b_beat%0d: got r%0d c%0d l%0b w=%h want r%0d c%0d l%0b w=%h", i,
                 obs_row[i], obs_col[i], obs_last[i], obs_win[i],
                 exp_row[i], exp_col[i], exp_last[i], exp_win[i]);
      end
    end
  endtask

  task automatic test_reset_midscan();
    bit to; int ncyc, se;
    tile_t t;
    t = rand_tile();
    ready_out = 1;
    send_tile(t, 2'd1, to);
    collect(10, 100, to, ncyc, se);
    checks++;
    if (to || obs_row.size() != 10 || valid_out !== 1) begin
      errors++;
      $display("FAIL rstmid_pre: to=%b beats=%0d vld=%b want 10 beats vld 1", to, obs_row.size(), valid_out);
    end
    rst_n = 0;
    #1;
    checks++;
    if (valid_out !== 0 || ready_in !== 1 || win_last !== 0 || window_out !== '0 ||
        win_row !== 0 || win_col !== 0) begin
      errors++;
      $display("FAIL rstmid_low: vld=%b rdy_in=%b last=%b r%0d c%0d w=%h want all reset values",
               valid_out, ready_in, win_last, win_row, win_col, window_out);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (valid_out !== 0 || ready_in !== 1 || win_last !== 0 || window_out !== '0) begin
      errors++;
      $display("FAIL rstmid_release: vld=%b rdy_in=%b last=%b w=%h want 0 1 0 0", valid_out, ready_in, win_last, window_out);
    end
    t = rand_tile();
    build_exp(t, 3);
    send_tile(t, 2'd3, to);
    collect(0, 100, to, ncyc, se);
    checks++;
    if (to || obs_row.size() != 9) begin
      errors++;
      $display("FAIL rstmid_new_count: to=%b beats=%0d want 9", to, obs_row.size());
    end
    for (int i = 0; i < obs_row.size() && i < exp_row.size(); i++) begin
      checks++;
      if (obs_row[i] != exp_row[i] || obs_col[i] != exp_col[i] ||
          obs_last[i] != exp_last[i] || obs_win[i] !== exp_win[i]) begin
        errors++;
        $display("FAIL rstmid_new_beat%0d: got r%0d c%0d l%0b w=%h want r%0d c%0d l%0b w=%h", i,
                 obs_row[i], obs_col[i], obs_last[i], obs_win[i],
                 exp_row[i], exp_col[i], exp_last[i], exp_win[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stride1_ramp();
    test_strides();
    test_backpressure();
    test_valid_in_during_scan();
    test_reset_midscan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
